spi_bridge_sm: RTL and testbench
================================

SPI_BRIDGE_SM -- requirements
Module: spi_bridge_sm

Interface
REQ-001 The block SHALL have these parameters:
- DATA_W, 32, SPI word and Avalon data width; multiple of 8, power of 2, 16..64.
- ADDR_W, 30, Avalon address width; at most DATA_W-2.
- CNT_W, 7, bit_cnt width.
- TIMEOUT_CYC, 255, maximum clock cycles to wait for ack, 1..65535.

REQ-002 The block SHALL have these ports:
- clock  in  1  single clock.
- nreset  in  1  reset; asynchronous, active-low.
- csn  in  1  SPI chip select; high = no frame.
- bit_cnt  in  CNT_W  SPI bit position in the frame.
- data_from_spi  in  DATA_W  last full word received over SPI.
- read_data_from_avalon  in  DATA_W  Avalon read data.
- ack  in  1  Avalon transfer complete.
- read  out  1  Avalon read request.
- write  out  1  Avalon write request.
- byte_enable  out  DATA_W/8  Avalon byte enables.
- address  out  ADDR_W  Avalon byte address.
- write_data_to_avalon  out  DATA_W  Avalon write data.
- read_data_to_spi  out  DATA_W  word for the SPI shifter.
- busy  out  1  Avalon request outstanding.
- err  out  1  sticky timeout error for the current frame.
- xfer_cnt  out  16  Avalon transfers completed in the current frame.

Function
REQ-003 The block SHALL register ack, bit_cnt, data_from_spi and read_data_from_avalon through one clock stage; all decisions use the registered copies.

REQ-004 A word boundary SHALL be a one-cycle event that fires when registered bit_cnt changes to a nonzero multiple of DATA_W.

REQ-005 The first word of a frame SHALL be the header:
- bit DATA_W-1 = 1 for read, 0 for write.
- bit DATA_W-2 = 1 for fixed-address mode (no increment).
- bits ADDR_W-1:0 = start address.

REQ-006 The state machine SHALL have these states:
- IDLE -> GET_HDR unconditionally.
- GET_HDR -> RD_REQ on header boundary with the read bit set.
- GET_HDR -> WR_WAIT on header boundary with the read bit clear.
- RD_REQ -> RD_SHIFT on ack.
- RD_SHIFT -> RD_REQ on the next word boundary.
- WR_WAIT -> WR_REQ on a word boundary.
- WR_REQ -> WR_WAIT on ack.

REQ-007 In RD_REQ and WR_REQ, read or write SHALL be held at 1, byte_enable at all ones and busy at 1 until the cycle after the registered ack is seen; all three are 0 in every other state.

REQ-008 On a read ack, read_data_to_spi SHALL load read_data_from_avalon unchanged.

REQ-009 On entry to WR_REQ, write_data_to_avalon SHALL load data_from_spi byte-reversed (byte 0 becomes the most significant byte) and hold it until the next WR_REQ.

REQ-010 On RD_SHIFT->RD_REQ and WR_REQ->WR_WAIT, address SHALL increment by DATA_W/8 modulo 2^ADDR_W (wrap silently), unless fixed-address mode is set.

REQ-011 xfer_cnt SHALL increment on every acked transfer and saturate at 0xFFFF.

REQ-012 A word boundary arriving while in RD_REQ or WR_REQ SHALL be ignored; the Avalon transfer completes first.

REQ-013 An ack arriving outside RD_REQ or WR_REQ SHALL be ignored.

Reset
REQ-014 When nreset is low or csn is high, asynchronously:
- state = IDLE.
- all outputs = 0, including err and xfer_cnt.
- the synchroniser registers are cleared.

REQ-015 csn rising mid-transfer SHALL drop read and write immediately without waiting for ack; the next frame starts clean from IDLE.

Configuration
REQ-016 With ACK_TIMEOUT_EN defined, a cycle counter SHALL run in RD_REQ and WR_REQ; when it reaches TIMEOUT_CYC without ack:
- the request is dropped and err is set.
- on a read, read_data_to_spi loads all ones.
- the state machine advances as if acked, with address incremented and xfer_cnt not incremented.

REQ-017 Without ACK_TIMEOUT_EN, the counter and timeout logic SHALL be absent, err SHALL be tied to 0, and requests wait for ack indefinitely.

Verification
REQ-018 The bench SHALL cover these scenarios (DATA_W=32, ADDR_W=30):
- Single write: header 0x00000010, data 0x11223344, ack after 3 cycles -> write=1 with address=0x10, write_data_to_avalon=0x44332211, byte_enable=0xF; xfer_cnt=1.
- Burst read of 3 words from 0x20: header 0x80000020, ack each after 2 cycles -> addresses 0x20, 0x24, 0x28; read_data_to_spi follows the Avalon data; xfer_cnt=3.
- Fixed-address write burst: header 0x40000100, 4 data words -> all 4 writes at 0x100.
- Address wrap: write header 0x3FFFFFFC, 2 words -> addresses 0x3FFFFFFC then 0x00000000.
- csn raised 1 cycle into RD_REQ, before ack -> read=0 in that cycle; state IDLE, all outputs 0.
- With ACK_TIMEOUT_EN, TIMEOUT_CYC=8, read with ack never asserted -> read drops after 8 cycles; err=1, read_data_to_spi=0xFFFFFFFF, xfer_cnt=0.

Source files
------------

// File: rtl/spi_bridge_sm.sv
// SPI-frame to Avalon-MM master: a header word (rd/wr, fixed-address, start address), then one transfer per word.
// Inputs are registered once; build with ACK_TIMEOUT_EN for a per-request ack timeout with sticky err.
module spi_bridge_sm #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 30,
    parameter int CNT_W       = 7,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clock,
    input  logic                nreset,
    input  logic                csn,
    input  logic [CNT_W-1:0]    bit_cnt,
    input  logic [DATA_W-1:0]   data_from_spi,
    input  logic [DATA_W-1:0]   read_data_from_avalon,
    input  logic                ack,
    output logic                read,
    output logic                write,
    output logic [DATA_W/8-1:0] byte_enable,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W-1:0]   write_data_to_avalon,
    output logic [DATA_W-1:0]   read_data_to_spi,
    output logic                busy,
    output logic                err,
    output logic [15:0]         xfer_cnt
);
    localparam int BE_W  = DATA_W / 8;
    localparam int LSB_W = $clog2(DATA_W);

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("spi_bridge_sm: TIMEOUT_CYC must be 1..65535");
    end
    if (CNT_W <= LSB_W || ADDR_W > DATA_W - 2) begin : g_bad_width
        $error("spi_bridge_sm: CNT_W or ADDR_W out of range");
    end

    typedef enum logic [2:0] {
        IDLE, GET_HDR, RD_REQ, RD_SHIFT, WR_WAIT, WR_REQ
    } state_t;

    // A deselected frame holds everything in reset, so csn aborts a request instantly.
    logic frame_rst_n;
    assign frame_rst_n = nreset & ~csn;

    logic              ack_q;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_prev_q;
    logic [DATA_W-1:0] spi_dat_q, avl_dat_q;

    always_ff @(posedge clock or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            ack_q          <= 1'b0;
            bit_cnt_q      <= '0;
            bit_cnt_prev_q <= '0;
            spi_dat_q      <= '0;
            avl_dat_q      <= '0;
        end else begin
            ack_q          <= ack;
            bit_cnt_q      <= bit_cnt;
            bit_cnt_prev_q <= bit_cnt_q;
            spi_dat_q      <= data_from_spi;
            avl_dat_q      <= read_data_from_avalon;
        end
    end

    logic word_bnd;
    assign word_bnd = (bit_cnt_q != bit_cnt_prev_q) && (bit_cnt_q != '0)
                      && (bit_cnt_q[LSB_W-1:0] == '0);

    logic [DATA_W-1:0] wr_swap;
    always_comb begin
        wr_swap = '0;
        for (int b = 0; b < BE_W; b++) begin
            wr_swap[8*(BE_W-1-b) +: 8] = spi_dat_q[8*b +: 8];
        end
    end

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_next;
    logic              fixed_q, fixed_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [15:0]       xfer_q, xfer_d;
    logic              in_req;
    logic              tmo;

    assign in_req    = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign addr_next = fixed_q ? addr_q : addr_q + ADDR_W'(BE_W);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        fixed_d = fixed_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        xfer_d  = xfer_q;
        unique case (state_q)
            IDLE: state_d = GET_HDR;
            GET_HDR: begin
                if (word_bnd) begin
                    addr_d  = spi_dat_q[ADDR_W-1:0];
                    fixed_d = spi_dat_q[DATA_W-2];
                    state_d = spi_dat_q[DATA_W-1] ? RD_REQ : WR_WAIT;
                end
            end
            RD_REQ: begin
                if (ack_q) begin
                    rdata_d = avl_dat_q;
                    state_d = RD_SHIFT;
                    if (xfer_q != 16'hFFFF) xfer_d = xfer_q + 16'd1;
                end else if (tmo) begin
                    rdata_d = '1;
                    state_d = RD_SHIFT;
                end
            end
            RD_SHIFT: begin
                if (word_bnd) begin
                    addr_d  = addr_next;
                    state_d = RD_REQ;
                end
            end
            WR_WAIT: begin
                if (word_bnd) begin
                    wdata_d = wr_swap;
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                if (ack_q || tmo) begin
                    addr_d  = addr_next;
                    state_d = WR_WAIT;
                    if (ack_q && xfer_q != 16'hFFFF) xfer_d = xfer_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            fixed_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            xfer_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            fixed_q <= fixed_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            xfer_q  <= xfer_d;
        end
    end

`ifdef ACK_TIMEOUT_EN
    // Counts cycles spent in the current request; restarts at 0 on every entry.
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        err_q, err_d;

    assign tmo = in_req && !ack_q && (tmo_cnt_q == 16'(TIMEOUT_CYC - 1));

    always_comb begin
        tmo_cnt_d = '0;
        err_d     = err_q | tmo;
        if (in_req && (state_d == state_q)) tmo_cnt_d = tmo_cnt_q + 16'd1;
    end

    always_ff @(posedge clock or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign err = err_q;
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    assign read                 = (state_q == RD_REQ);
    assign write                = (state_q == WR_REQ);
    assign busy                 = in_req;
    assign byte_enable          = {BE_W{in_req}};
    assign address              = addr_q;
    assign write_data_to_avalon = wdata_q;
    assign read_data_to_spi     = rdata_q;
    assign xfer_cnt             = xfer_q;
endmodule

// File: tb/tb_spi_bridge_sm.sv
// Bench for spi_bridge_sm: spec-scenario table, abort/ignore/timeout sequences, random frames vs a transaction model.
module tb_spi_bridge_sm;
    localparam int DW = 32, AW = 30, CW = 10, TO = 8, GAP = 14;

    logic          clock, nreset, csn, ack;
    logic [CW-1:0] bit_cnt;
    logic [DW-1:0] data_from_spi, read_data_from_avalon;
    logic          read, write, busy, err;
    logic [3:0]    byte_enable;
    logic [AW-1:0] address;
    logic [DW-1:0] write_data_to_avalon, read_data_to_spi;
    logic [15:0]   xfer_cnt;

    spi_bridge_sm #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .TIMEOUT_CYC(TO)) dut (
        .clock(clock), .nreset(nreset), .csn(csn), .bit_cnt(bit_cnt),
        .data_from_spi(data_from_spi), .read_data_from_avalon(read_data_from_avalon),
        .ack(ack), .read(read), .write(write), .byte_enable(byte_enable),
        .address(address), .write_data_to_avalon(write_data_to_avalon),
        .read_data_to_spi(read_data_to_spi), .busy(busy), .err(err), .xfer_cnt(xfer_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0, bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } txn_t;
    txn_t exp_q[$];

    function automatic logic [DW-1:0] bswap(input logic [DW-1:0] w);
        logic [DW-1:0] r;
        for (int b = 0; b < DW/8; b++) r[8*b +: 8] = w[DW-8-8*b +: 8];
        return r;
    endfunction

    // Avalon slave: acks each request ack_dly cycles after it first appears, checks it against exp_q.
    int            ack_dly;
    logic          stray_ack;
    logic [DW-1:0] last_rd;
    initial begin
        bit pending, acked, was_rd;
        int wcnt;
        txn_t e;
        ack = 1'b0; read_data_from_avalon = '0; pending = 0; acked = 0; was_rd = 0; wcnt = 0;
        last_rd = '0;
        forever begin
            @(negedge clock);
            ack = stray_ack;
            if (pending && !(read || write)) begin
                pending = 0;
                if (acked && was_rd) check("rd_to_spi", 64'(read_data_to_spi), 64'(last_rd));
            end
            if (!pending && (read || write)) begin
                pending = 1; acked = 0; wcnt = 0; was_rd = read;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL txn_unexpected: got rd=%0b addr=%h want no request", read, address);
                end else begin
                    e = exp_q.pop_front();
                    check("txn_type", 64'(read), 64'(e.rd));
                    check("txn_addr", 64'(address), 64'(e.addr));
                    check("txn_be", 64'(byte_enable), 64'hF);
                    if (!e.rd) check("txn_wdata", 64'(write_data_to_avalon), 64'(e.wd));
                end
            end
            if (pending && !acked) begin
                if (wcnt >= ack_dly) begin
                    last_rd = $urandom;
                    read_data_from_avalon = last_rd;
                    ack = 1'b1; acked = 1;
                end else wcnt++;
            end
        end
    end

    task automatic idle_check(input string tag);
        check({tag, "_ctl"}, 64'({read, write, busy, err, byte_enable, xfer_cnt}), 64'h0);
        check({tag, "_addr"}, 64'(address), 64'h0);
        check({tag, "_wd"}, 64'(write_data_to_avalon), 64'h0);
        check({tag, "_rspi"}, 64'(read_data_to_spi), 64'h0);
    endtask

    task automatic start_frame();
        csn = 1'b0; bit_cnt = '0; data_from_spi = '0;
        repeat (3) @(negedge clock);
    endtask

    task automatic send_word(input logic [DW-1:0] w, input int idx, input int gap);
        data_from_spi = w;
        bit_cnt = CW'(DW * idx);
        repeat (gap) @(negedge clock);
    endtask

    task automatic drive_frame(input logic [DW-1:0] hdr, input logic [7:0][DW-1:0] w,
                               input int nw, input int dly);
        ack_dly = dly;
        start_frame();
        send_word(hdr, 1, GAP);
        for (int k = 0; k < nw; k++) send_word(w[k], k + 2, GAP);
    endtask

    task automatic end_frame(input int nx, input logic e, input logic [DW-1:0] wd, input string tag);
        check({tag, "_xfer"}, 64'(xfer_cnt), 64'(nx));
        check({tag, "_left"}, 64'(exp_q.size()), 64'h0);
        check({tag, "_err"}, 64'(err), 64'(e));
        check({tag, "_wdhold"}, 64'(write_data_to_avalon), 64'(wd));
        exp_q.delete();
        csn = 1'b1;
        @(negedge clock);
        idle_check({tag, "_end"});
    endtask

    // Frame model: a read frame reads once per boundary (header included), a write frame writes once per data word.
    task automatic model_frame(input logic [DW-1:0] hdr, input logic [7:0][DW-1:0] w, input int nw,
                               output int nx, output logic [DW-1:0] lastwd);
        txn_t t;
        nx = hdr[DW-1] ? nw + 1 : nw;
        lastwd = '0;
        for (int k = 0; k < nx; k++) begin
            t.rd   = hdr[DW-1];
            t.addr = hdr[DW-2] ? hdr[AW-1:0] : hdr[AW-1:0] + AW'(4 * k);
            t.wd   = hdr[DW-1] ? '0 : bswap(w[k]);
            if (!hdr[DW-1]) lastwd = t.wd;
            exp_q.push_back(t);
        end
    endtask

    typedef struct packed {
        logic [31:0]          hdr;
        int                   nw;
        int                   dly;
        int                   nx;
        logic [3:0][DW-1:0]   w;
        logic [3:0][AW-1:0]   ea;
        logic [3:0][DW-1:0]   ed;
    } vec_t;
    vec_t vec[5];

    initial begin
        watchdog_guard();
    end

    task automatic watchdog_guard();
        #1ms;
        $display("FAIL watchdog: got no finish want finish before 1ms");
        $fatal(1, "watchdog");
    endtask

    initial begin
        logic [7:0][DW-1:0] w8;
        int n;
        txn_t t;

        // element [0] is the rightmost entry of each concatenation
        vec[0] = '{hdr: 32'h0000_0010, nw: 1, dly: 3, nx: 1,
                   w:  {96'h0, 32'h1122_3344},
                   ea: {90'h0, 30'h10},
                   ed: {96'h0, 32'h4433_2211}};
        vec[1] = '{hdr: 32'h8000_0020, nw: 2, dly: 2, nx: 3,
                   w:  128'h0,
                   ea: {30'h0, 30'h28, 30'h24, 30'h20},
                   ed: 128'h0};
        vec[2] = '{hdr: 32'h4000_0100, nw: 4, dly: 1, nx: 4,
                   w:  {32'hCAFE_F00D, 32'h89AB_CDEF, 32'h0123_4567, 32'hA1B2_C3D4},
                   ea: {30'h100, 30'h100, 30'h100, 30'h100},
                   ed: {32'h0DF0_FECA, 32'hEFCD_AB89, 32'h6745_2301, 32'hD4C3_B2A1}};
        vec[3] = '{hdr: 32'h3FFF_FFFC, nw: 2, dly: 0, nx: 2,
                   w:  {64'h0, 32'h0506_0708, 32'h0102_0304},
                   ea: {60'h0, 30'h0, 30'h3FFF_FFFC},
                   ed: {64'h0, 32'h0807_0605, 32'h0403_0201}};
        vec[4] = '{hdr: 32'hC000_0040, nw: 1, dly: 4, nx: 2,
                   w:  128'h0,
                   ea: {60'h0, 30'h40, 30'h40},
                   ed: 128'h0};

        nreset = 1'b0; csn = 1'b0; bit_cnt = '0; data_from_spi = '0;
        stray_ack = 1'b0; ack_dly = 0;
        repeat (2) @(negedge clock);
        idle_check("reset");
        nreset = 1'b1; csn = 1'b1;
        @(negedge clock);

        foreach (vec[i]) begin
            for (int k = 0; k < vec[i].nx; k++) begin
                t.rd = vec[i].hdr[31]; t.addr = vec[i].ea[k]; t.wd = vec[i].ed[k];
                exp_q.push_back(t);
            end
            w8 = {128'h0, vec[i].w};
            drive_frame(vec[i].hdr, w8, vec[i].nw, vec[i].dly);
            end_frame(vec[i].nx, 1'b0, vec[i].hdr[31] ? 32'h0 : vec[i].ed[vec[i].nx-1],
                      $sformatf("vec%0d", i));
        end

        // csn raised one cycle into a read request, before any ack
        ack_dly = 1000;
        start_frame();
        exp_q.push_back('{rd: 1'b1, addr: 30'h80, wd: 32'h0});
        data_from_spi = 32'h8000_0080; bit_cnt = CW'(32);
        n = 0;
        while (!read && n < 10) begin @(negedge clock); n++; end
        check("abort_rd_seen", 64'(read), 64'h1);
        @(negedge clock);
        csn = 1'b1;
        #1;
        check("abort_rd_drop", 64'({read, busy}), 64'h0);
        @(negedge clock);
        idle_check("abort");
        exp_q.delete();
        exp_q.push_back('{rd: 1'b0, addr: 30'h50, wd: 32'hDDCC_BBAA});
        w8 = '0; w8[0] = 32'hAABB_CCDD;
        drive_frame(32'h0000_0050, w8, 1, 2);
        end_frame(1, 1'b0, 32'hDDCC_BBAA, "after_abort");

        // boundary during WR_REQ is dropped; stray ack in WR_WAIT is ignored
        ack_dly = 5;
        start_frame();
        exp_q.push_back('{rd: 1'b0, addr: 30'h200, wd: 32'h4433_2211});
        exp_q.push_back('{rd: 1'b0, addr: 30'h204, wd: 32'hCCBB_AA99});
        send_word(32'h0000_0200, 1, GAP);
        data_from_spi = 32'h1122_3344; bit_cnt = CW'(64);
        n = 0;
        while (!write && n < 10) begin @(negedge clock); n++; end
        check("ign_wr_seen", 64'(write), 64'h1);
        @(negedge clock);
        send_word(32'h5566_7788, 3, GAP);
        #2 stray_ack = 1'b1;
        @(negedge clock);
        #2 stray_ack = 1'b0;
        repeat (3) @(negedge clock);
        check("ign_stray", 64'({write, xfer_cnt}), 64'h1);
        send_word(32'h99AA_BBCC, 4, GAP);
        end_frame(2, 1'b0, 32'hCCBB_AA99, "ignore");

`ifdef ACK_TIMEOUT_EN
        ack_dly = 1000;
        start_frame();
        exp_q.push_back('{rd: 1'b1, addr: 30'h300, wd: 32'h0});
        data_from_spi = 32'h8000_0300; bit_cnt = CW'(32);
        n = 0;
        while (!read && n < 10) begin @(negedge clock); n++; end
        n = 0;
        while (read && n < 50) begin @(negedge clock); n++; end
        check("tmo_len", 64'(n), 64'(TO));
        check("tmo_err", 64'(err), 64'h1);
        check("tmo_rspi", 64'(read_data_to_spi), 64'hFFFF_FFFF);
        check("tmo_xfer", 64'(xfer_cnt), 64'h0);
        exp_q.push_back('{rd: 1'b1, addr: 30'h304, wd: 32'h0});
        ack_dly = 2;
        send_word(32'h0, 2, GAP);
        end_frame(1, 1'b1, 32'h0, "tmo");
`endif

        for (int r = 0; r < 30; r++) begin
            logic [DW-1:0] hdr, lastwd;
            int nw, nx;
            hdr = $urandom;
            if (r % 3 == 0) hdr[29:4] = '1;
            nw = $urandom_range(1, 6);
            for (int k = 0; k < 8; k++) w8[k] = $urandom;
            model_frame(hdr, w8, nw, nx, lastwd);
            drive_frame(hdr, w8, nw, $urandom_range(0, 4));
            end_frame(nx, 1'b0, lastwd, $sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
